// File: rtl/program_sequencer_pkg.sv
// Shared types for the program sequencer: branch conditions, status flag
// positions and return-address-stack operations.
package program_sequencer_pkg;

    typedef enum logic [2:0] {
        ZERO             = 3'd0,
        NOT_ZERO         = 3'd1,
        NEGATIVE         = 3'd2,
        POSITIVE         = 3'd3,
        CARRY_SET        = 3'd4,
        CARRY_CLEARED    = 3'd5,
        OVERFLOW_SET     = 3'd6,
        OVERFLOW_CLEARED = 3'd7
    } branch_condition_e;

    localparam int FLAG_ZERO     = 0;
    localparam int FLAG_NEGATIVE = 1;
    localparam int FLAG_CARRY    = 2;
    localparam int FLAG_OVERFLOW = 3;

    typedef enum logic [1:0] {
        RAS_NONE    = 2'd0,
        RAS_PUSH    = 2'd1,
        RAS_POP     = 2'd2,
        RAS_REPLACE = 2'd3
    } ras_op_e;

    // Pointer width for a power-of-two stack depth; count needs one bit more.
    function automatic int ras_ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/program_sequencer_if.sv
// Decoder/status side of the program sequencer: control inputs in, fetch
// address and return-stack status out.
interface program_sequencer_if #(
    parameter int I_ADDR_W  = 12,
    parameter int DATA_W    = 8,
    parameter int RAS_DEPTH = 8
);
    localparam int CNT_W = program_sequencer_pkg::ras_ptr_w(RAS_DEPTH) + 1;

    logic                                   stall;
    logic [I_ADDR_W-1:0]                    imar;
    logic [I_ADDR_W-1:0]                    address_immediate;
    logic                                   immediate_select;
    logic                                   pc_relative;
    logic                                   jump_branch_select;
    logic                                   unconditional_branch;
    program_sequencer_pkg::branch_condition_e branch_condition;
    logic [DATA_W-1:0]                      status_register;
    logic                                   call;
    logic                                   ret;
    logic                                   ras_err_clear;

    logic [I_ADDR_W-1:0]                    pc;
    logic [CNT_W-1:0]                       ras_count;
    logic                                   ras_overflow;
    logic                                   ras_underflow;

    modport master (
        output stall, imar, address_immediate, immediate_select, pc_relative,
               jump_branch_select, unconditional_branch, branch_condition,
               status_register, call, ret, ras_err_clear,
        input  pc, ras_count, ras_overflow, ras_underflow
    );

    modport slave (
        input  stall, imar, address_immediate, immediate_select, pc_relative,
               jump_branch_select, unconditional_branch, branch_condition,
               status_register, call, ret, ras_err_clear,
        output pc, ras_count, ras_overflow, ras_underflow
    );

endinterface

// File: rtl/program_sequencer_return_address_stack.sv
// Circular return-address stack: pushing while full overwrites the oldest
// entry, popping while empty leaves the stack untouched.
module return_address_stack
    import program_sequencer_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 12
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  ras_op_e                   i_op,
    input  logic [ADDR_W-1:0]         i_push_data,
    output logic [ADDR_W-1:0]         o_top,
    output logic [ras_ptr_w(DEPTH):0] o_count,
    output logic                      o_full,
    output logic                      o_empty
);
    localparam int PTR_W = ras_ptr_w(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    logic [ADDR_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [PTR_W-1:0]  w_ptr_up;
    logic [PTR_W-1:0]  w_ptr_down;

    assign w_ptr_up   = r_ptr + PTR_W'(1);
    assign w_ptr_down = r_ptr - PTR_W'(1);
    assign o_full     = (r_count == FULL_COUNT);
    assign o_empty    = (r_count == '0);
    assign o_top      = r_mem[r_ptr];
    assign o_count    = r_count;

    // When full, the slot above the top is the oldest entry, so a push there discards it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr   <= '0;
            r_count <= '0;
        end else begin
            case (i_op)
                RAS_PUSH: begin
                    r_ptr <= w_ptr_up;
                    if (!o_full) begin
                        r_count <= r_count + CNT_W'(1);
                    end
                end
                RAS_POP: begin
                    if (!o_empty) begin
                        r_ptr   <= w_ptr_down;
                        r_count <= r_count - CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (i_op == RAS_PUSH) begin
            r_mem[w_ptr_up] <= i_push_data;
        end else if (i_op == RAS_REPLACE) begin
            r_mem[r_ptr] <= i_push_data;
        end
    end

endmodule

// File: rtl/program_sequencer.sv
// Program counter with sequential/jump/branch sequencing, call/return via a
// circular return-address stack, pipeline stall and sticky stack error flags.
module program_sequencer
    import program_sequencer_pkg::*;
#(
    parameter int                  I_ADDR_W     = 12,
    parameter int                  INST_W_BYTES = 2,
    parameter int                  DATA_W       = 8,
    parameter int                  RAS_DEPTH    = 8,
    parameter logic [I_ADDR_W-1:0] RESET_VECTOR = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    program_sequencer_if.slave sif
);
    localparam int CNT_W = ras_ptr_w(RAS_DEPTH) + 1;

    logic [I_ADDR_W-1:0] r_pc;
    logic                r_overflow;
    logic                r_underflow;

    logic [I_ADDR_W-1:0] w_pc_inc;
    logic [I_ADDR_W-1:0] w_target;
    logic [I_ADDR_W-1:0] w_dest;
    logic [I_ADDR_W-1:0] w_next_pc;
    logic                w_cond_true;
    logic                w_taken;
    ras_op_e             w_ras_op;
    logic [I_ADDR_W-1:0] w_ras_top;
    logic [CNT_W-1:0]    w_ras_count;
    logic                w_ras_full;
    logic                w_ras_empty;
    logic                w_overflow_set;
    logic                w_underflow_set;
    logic                w_unused_status;

    // All address arithmetic wraps modulo 2^I_ADDR_W by truncation.
    assign w_pc_inc = r_pc + I_ADDR_W'(INST_W_BYTES);
    assign w_target = sif.immediate_select ? sif.address_immediate : sif.imar;
    assign w_dest   = sif.pc_relative ? (r_pc + w_target) : w_target;

    assign w_unused_status = ^sif.status_register;

    always_comb begin
        w_cond_true = 1'b0;
        case (sif.branch_condition)
            ZERO:             w_cond_true =  sif.status_register[FLAG_ZERO];
            NOT_ZERO:         w_cond_true = ~sif.status_register[FLAG_ZERO];
            NEGATIVE:         w_cond_true =  sif.status_register[FLAG_NEGATIVE];
            POSITIVE:         w_cond_true = ~sif.status_register[FLAG_NEGATIVE];
            CARRY_SET:        w_cond_true =  sif.status_register[FLAG_CARRY];
            CARRY_CLEARED:    w_cond_true = ~sif.status_register[FLAG_CARRY];
            OVERFLOW_SET:     w_cond_true =  sif.status_register[FLAG_OVERFLOW];
            OVERFLOW_CLEARED: w_cond_true = ~sif.status_register[FLAG_OVERFLOW];
            default:          w_cond_true = 1'b0;
        endcase
    end

    assign w_taken = sif.jump_branch_select & (sif.unconditional_branch | w_cond_true);

    always_comb begin
        w_next_pc = w_pc_inc;
        w_ras_op  = RAS_NONE;
        if (sif.stall) begin
            w_next_pc = r_pc;
        end else if (sif.call && !sif.ret) begin
            w_ras_op  = RAS_PUSH;
            w_next_pc = w_dest;
        end else if (sif.ret && !sif.call) begin
            w_ras_op  = RAS_POP;
            w_next_pc = w_ras_empty ? w_pc_inc : w_ras_top;
        end else if (sif.call && sif.ret) begin
            // Tail call on an empty stack degenerates to a plain call.
            w_ras_op  = w_ras_empty ? RAS_PUSH : RAS_REPLACE;
            w_next_pc = w_dest;
        end else if (w_taken) begin
            w_next_pc = w_dest;
        end
    end

    assign w_overflow_set  = (w_ras_op == RAS_PUSH) & w_ras_full;
    assign w_underflow_set = (w_ras_op == RAS_POP)  & w_ras_empty;

    return_address_stack #(
        .DEPTH  (RAS_DEPTH),
        .ADDR_W (I_ADDR_W)
    ) u_ras (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_op        (w_ras_op),
        .i_push_data (w_pc_inc),
        .o_top       (w_ras_top),
        .o_count     (w_ras_count),
        .o_full      (w_ras_full),
        .o_empty     (w_ras_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc        <= RESET_VECTOR;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_pc        <= w_next_pc;
            r_overflow  <= w_overflow_set  | (r_overflow  & ~sif.ras_err_clear);
            r_underflow <= w_underflow_set | (r_underflow & ~sif.ras_err_clear);
        end
    end

    assign sif.pc            = r_pc;
    assign sif.ras_count     = w_ras_count;
    assign sif.ras_overflow  = r_overflow;
    assign sif.ras_underflow = r_underflow;

endmodule

// File: tb/tb_program_sequencer.sv
// Directed bench for program_sequencer: sequencing, branches, call/return,
// stack overflow/underflow, tail call, stall and asynchronous reset.
module tb_program_sequencer;
    import program_sequencer_pkg::*;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fails;

    program_sequencer_if #(.I_ADDR_W(12), .DATA_W(8), .RAS_DEPTH(8)) sif ();

    program_sequencer #(
        .I_ADDR_W     (12),
        .INST_W_BYTES (2),
        .DATA_W       (8),
        .RAS_DEPTH    (8),
        .RESET_VECTOR (12'h000)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sif   (sif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic idle();
        sif.stall                = 1'b0;
        sif.imar                 = '0;
        sif.address_immediate    = '0;
        sif.immediate_select     = 1'b0;
        sif.pc_relative          = 1'b0;
        sif.jump_branch_select   = 1'b0;
        sif.unconditional_branch = 1'b0;
        sif.branch_condition     = ZERO;
        sif.status_register      = '0;
        sif.call                 = 1'b0;
        sif.ret                  = 1'b0;
        sif.ras_err_clear        = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic jump_to(input logic [11:0] addr);
        idle();
        sif.jump_branch_select   = 1'b1;
        sif.unconditional_branch = 1'b1;
        sif.immediate_select     = 1'b1;
        sif.address_immediate    = addr;
        tick();
        idle();
    endtask

    task automatic do_call(input logic [11:0] target);
        idle();
        sif.call              = 1'b1;
        sif.immediate_select  = 1'b1;
        sif.address_immediate = target;
        tick();
        idle();
    endtask

    task automatic do_ret();
        idle();
        sif.ret = 1'b1;
        tick();
        idle();
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_pc", 32'(sif.pc), 32'h000);
        check_eq("reset_count", 32'(sif.ras_count), 32'd0);
        check_eq("reset_ovf", 32'(sif.ras_overflow), 32'd0);
        check_eq("reset_udf", 32'(sif.ras_underflow), 32'd0);
        #3 rst_n = 1'b1;
        check_eq("pc_after_release", 32'(sif.pc), 32'h000);

        for (int i = 1; i <= 3; i++) begin
            tick();
            check_eq("seq_pc", 32'(sif.pc), 32'(2 * i));
        end
        sif.stall = 1'b1;
        tick();
        check_eq("stall_pc1", 32'(sif.pc), 32'h006);
        tick();
        check_eq("stall_pc2", 32'(sif.pc), 32'h006);
        idle();

        jump_to(12'h100);
        check_eq("jump_abs", 32'(sif.pc), 32'h100);
        sif.jump_branch_select = 1'b1;
        sif.pc_relative        = 1'b1;
        sif.immediate_select   = 1'b1;
        sif.address_immediate  = 12'hFFE;
        sif.branch_condition   = ZERO;
        sif.status_register    = 8'h01;
        tick();
        check_eq("br_zero_taken", 32'(sif.pc), 32'h0FE);
        idle();

        jump_to(12'h100);
        sif.jump_branch_select = 1'b1;
        sif.pc_relative        = 1'b1;
        sif.immediate_select   = 1'b1;
        sif.address_immediate  = 12'hFFE;
        sif.branch_condition   = ZERO;
        sif.status_register    = 8'h00;
        tick();
        check_eq("br_zero_not_taken", 32'(sif.pc), 32'h102);

        idle();
        sif.jump_branch_select = 1'b1;
        sif.pc_relative        = 1'b1;
        sif.imar               = 12'h010;
        sif.branch_condition   = CARRY_CLEARED;
        sif.status_register    = 8'hF0;
        tick();
        check_eq("br_carry_clr_imar", 32'(sif.pc), 32'h112);
        idle();
        sif.jump_branch_select = 1'b1;
        sif.immediate_select   = 1'b1;
        sif.address_immediate  = 12'h800;
        sif.branch_condition   = OVERFLOW_SET;
        sif.status_register    = 8'h07;
        tick();
        check_eq("br_ovf_not_taken", 32'(sif.pc), 32'h114);
        idle();

        jump_to(12'hFFE);
        tick();
        check_eq("pc_wrap", 32'(sif.pc), 32'h000);

        jump_to(12'h040);
        do_call(12'h200);
        check_eq("call_pc", 32'(sif.pc), 32'h200);
        check_eq("call_count", 32'(sif.ras_count), 32'd1);
        do_ret();
        check_eq("ret_pc", 32'(sif.pc), 32'h042);
        check_eq("ret_count", 32'(sif.ras_count), 32'd0);
        do_ret();
        check_eq("ret_empty_pc", 32'(sif.pc), 32'h044);
        check_eq("ret_empty_udf", 32'(sif.ras_underflow), 32'd1);
        check_eq("ret_empty_count", 32'(sif.ras_count), 32'd0);
        sif.ras_err_clear = 1'b1;
        tick();
        idle();
        check_eq("udf_cleared", 32'(sif.ras_underflow), 32'd0);
        sif.ret           = 1'b1;
        sif.ras_err_clear = 1'b1;
        tick();
        idle();
        check_eq("udf_set_wins", 32'(sif.ras_underflow), 32'd1);
        sif.ras_err_clear = 1'b1;
        tick();
        idle();

        jump_to(12'h010);
        for (int i = 1; i <= 8; i++) do_call(12'((i + 1) * 16));
        check_eq("nest8_count", 32'(sif.ras_count), 32'd8);
        check_eq("nest8_ovf", 32'(sif.ras_overflow), 32'd0);
        do_call(12'h0A0);
        check_eq("nest9_pc", 32'(sif.pc), 32'h0A0);
        check_eq("nest9_count", 32'(sif.ras_count), 32'd8);
        check_eq("nest9_ovf", 32'(sif.ras_overflow), 32'd1);
        for (int k = 0; k < 8; k++) begin
            do_ret();
            check_eq("nest_ret_pc", 32'(sif.pc), 32'(12'h092 - 12'(16 * k)));
        end
        check_eq("nest_drained", 32'(sif.ras_count), 32'd0);
        do_ret();
        check_eq("lost_entry_pc", 32'(sif.pc), 32'h024);
        check_eq("lost_entry_udf", 32'(sif.ras_underflow), 32'd1);
        sif.ras_err_clear = 1'b1;
        tick();
        idle();
        check_eq("ovf_cleared", 32'(sif.ras_overflow), 32'd0);
        check_eq("udf_cleared2", 32'(sif.ras_underflow), 32'd0);

        jump_to(12'h500);
        do_call(12'h700);
        do_call(12'h300);
        check_eq("tail_pre_count", 32'(sif.ras_count), 32'd2);
        sif.call              = 1'b1;
        sif.ret               = 1'b1;
        sif.immediate_select  = 1'b1;
        sif.address_immediate = 12'h400;
        tick();
        idle();
        check_eq("tail_pc", 32'(sif.pc), 32'h400);
        check_eq("tail_count", 32'(sif.ras_count), 32'd2);
        check_eq("tail_flags", 32'({sif.ras_overflow, sif.ras_underflow}), 32'd0);
        do_ret();
        check_eq("tail_ret1", 32'(sif.pc), 32'h302);
        do_ret();
        check_eq("tail_ret2", 32'(sif.pc), 32'h502);

        sif.stall             = 1'b1;
        sif.call              = 1'b1;
        sif.immediate_select  = 1'b1;
        sif.address_immediate = 12'h600;
        tick();
        idle();
        check_eq("stall_call_pc", 32'(sif.pc), 32'h502);
        check_eq("stall_call_count", 32'(sif.ras_count), 32'd0);

        do_ret();
        do_call(12'h200);
        check_eq("pre_rst_count", 32'(sif.ras_count), 32'd1);
        check_eq("pre_rst_udf", 32'(sif.ras_underflow), 32'd1);
        sif.call              = 1'b1;
        sif.immediate_select  = 1'b1;
        sif.address_immediate = 12'h250;
        #3 rst_n = 1'b0;
        #1;
        check_eq("async_rst_pc", 32'(sif.pc), 32'h000);
        check_eq("async_rst_count", 32'(sif.ras_count), 32'd0);
        check_eq("async_rst_flags", 32'({sif.ras_overflow, sif.ras_underflow}), 32'd0);
        idle();
        tick();
        check_eq("rst_hold_pc", 32'(sif.pc), 32'h000);
        #3 rst_n = 1'b1;
        tick();
        check_eq("post_rst_pc", 32'(sif.pc), 32'h002);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
